// File: rtl/muldiv_pkg.sv
// Shared encodings for the HI/LO multiply/divide sequencer: mul_control one-hot op codes,
// FSM states and the iteration count.
package muldiv_pkg;

  localparam logic [3:0] OP_MULT  = 4'b0001;
  localparam logic [3:0] OP_MULTU = 4'b0010;
  localparam logic [3:0] OP_DIV   = 4'b0100;
  localparam logic [3:0] OP_DIVU  = 4'b1000;

  localparam int unsigned ITER = 32;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StFix
  } state_e;

endpackage

// File: rtl/muldiv_iter.sv
// Iterative unsigned datapath: 32-step shift-add multiply or restoring divide on magnitudes.
// MULDIV_FAST_MUL_EN loads multiply products in one cycle on start instead of iterating.
module muldiv_iter
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             step_i,
  input  logic             is_div_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o,
  output logic             last_o
);

  logic [WIDTH-1:0] hi_q, lo_q, b_q;
  logic [WIDTH-1:0] hi_d, lo_d;
  logic [CNT_W-1:0] cnt_q;
  logic             div_q;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] diff;

`ifdef MULDIV_FAST_MUL_EN
  logic signed [2*WIDTH+1:0] fast_prod;
  logic                      unused_fast_hi;
  assign fast_prod      = $signed({1'b0, a_i}) * $signed({1'b0, b_i});
  assign unused_fast_hi = ^fast_prod[2*WIDTH+1:2*WIDTH];
`endif

  always_comb begin
    sum     = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
    shifted = {hi_q, lo_q[WIDTH-1]};
    diff    = {1'b0, shifted} - {2'b00, b_q};
    hi_d    = hi_q;
    lo_d    = lo_q;
    if (div_q) begin
      // Restore by simply keeping the shifted remainder when the trial subtract goes negative.
      if (!diff[WIDTH+1]) begin
        hi_d = diff[WIDTH-1:0];
        lo_d = {lo_q[WIDTH-2:0], 1'b1};
      end else begin
        hi_d = shifted[WIDTH-1:0];
        lo_d = {lo_q[WIDTH-2:0], 1'b0};
      end
    end else begin
      hi_d = sum[WIDTH:1];
      lo_d = {sum[0], lo_q[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hi_q  <= '0;
      lo_q  <= '0;
      b_q   <= '0;
      cnt_q <= '0;
      div_q <= 1'b0;
    end else if (start_i) begin
      cnt_q <= '0;
      div_q <= is_div_i;
      b_q   <= b_i;
`ifdef MULDIV_FAST_MUL_EN
      if (!is_div_i) begin
        {hi_q, lo_q} <= fast_prod[2*WIDTH-1:0];
      end else begin
        hi_q <= '0;
        lo_q <= a_i;
      end
`else
      hi_q <= '0;
      lo_q <= a_i;
`endif
    end else if (step_i) begin
      cnt_q <= cnt_q + CNT_W'(1);
      hi_q  <= hi_d;
      lo_q  <= lo_d;
    end
  end

  assign hi_o   = hi_q;
  assign lo_o   = lo_q;
  assign last_o = (cnt_q == CNT_W'(ITER - 1));

endmodule

// File: rtl/muldiv_ctrl.sv
// MIPS HI/LO multiply/divide sequencer: FSM, sign handling, HI/LO registers and stall.
// MULDIV_FAST_MUL_EN skips the iterative multiply and goes straight to sign fix-up.
module muldiv_ctrl
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             op_valid,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             flush,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  input  logic             hi_re,
  input  logic             lo_re,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

`ifdef MULDIV_FAST_MUL_EN
  localparam bit FAST_MUL = 1'b1;
`else
  localparam bit FAST_MUL = 1'b0;
`endif

  state_e             state_q;
  logic               busy_q, done_q;
  logic [WIDTH-1:0]   hi_q, lo_q;
  logic               div_q, res_neg_q, rem_neg_q;

  logic               op_ok, op_div, op_sgn;
  logic               a_neg, b_neg, accept;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH-1:0]   it_hi, it_lo, res_hi, res_lo;
  logic               it_last;
  logic [2*WIDTH-1:0] prod;

  always_comb begin
    op_ok  = 1'b1;
    op_div = 1'b0;
    op_sgn = 1'b0;
    unique case (op)
      OP_MULT:  op_sgn = 1'b1;
      OP_MULTU: ;
      OP_DIV:   begin op_div = 1'b1; op_sgn = 1'b1; end
      OP_DIVU:  op_div = 1'b1;
      default:  op_ok = 1'b0;
    endcase
  end

  assign a_neg  = op_sgn & src_a[WIDTH-1];
  assign b_neg  = op_sgn & src_b[WIDTH-1];
  assign a_mag  = a_neg ? -src_a : src_a;
  assign b_mag  = b_neg ? -src_b : src_b;
  assign accept = (state_q == StIdle) & op_valid & op_ok & ~flush;

  muldiv_iter #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_iter (
    .clk_i    (clk),
    .rst_i    (rst),
    .start_i  (accept),
    .step_i   (state_q == StRun),
    .is_div_i (op_div),
    .a_i      (a_mag),
    .b_i      (b_mag),
    .hi_o     (it_hi),
    .lo_o     (it_lo),
    .last_o   (it_last)
  );

  // Remainder follows the dividend's sign; quotient/product negate when operand signs differ.
  always_comb begin
    prod = {it_hi, it_lo};
    if (div_q) begin
      res_lo = res_neg_q ? -it_lo : it_lo;
      res_hi = rem_neg_q ? -it_hi : it_hi;
    end else begin
      {res_hi, res_lo} = res_neg_q ? -prod : prod;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      div_q     <= 1'b0;
      res_neg_q <= 1'b0;
      rem_neg_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (!flush && hi_we) hi_q <= wdata;
          if (!flush && lo_we) lo_q <= wdata;
          if (accept) begin
            div_q     <= op_div;
            res_neg_q <= a_neg ^ b_neg;
            rem_neg_q <= a_neg;
            busy_q    <= 1'b1;
            state_q   <= (FAST_MUL && !op_div) ? StFix : StRun;
          end
        end
        StRun: begin
          if (flush) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end else if (it_last) begin
            state_q <= StFix;
          end
        end
        StFix: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
          if (!flush) begin
            hi_q   <= res_hi;
            lo_q   <= res_lo;
            done_q <= 1'b1;
          end
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign hi    = hi_q;
  assign lo    = lo_q;
  assign stall = busy_q & (op_valid | hi_we | lo_we | hi_re | lo_re);

endmodule
